wb_rom_reader: RTL
==================

WB_ROM_READER -- requirements
Module: wb_rom_reader

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 12, giving the byte-address width of the attached ROM; legal values are >= 2.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, giving the Wishbone address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wb_adr_i, input, WB_ADDR_WIDTH bits: Wishbone byte address.
REQ-006 SHALL have port wb_cyc_i, input, 1 bit: Wishbone cycle.
REQ-007 SHALL have port wb_stb_i, input, 1 bit: Wishbone strobe.
REQ-008 SHALL have port wb_we_i, input, 1 bit: Wishbone write enable.
REQ-009 SHALL have port wb_sel_i, input, 4 bits: byte select; ignored on reads.
REQ-010 SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-011 SHALL have port wb_ack_o, output, 1 bit: transfer acknowledge.
REQ-012 SHALL have port wb_err_o, output, 1 bit: error acknowledge.
REQ-013 SHALL have port rom_addr_o, output, ROM_ADDR_WIDTH bits: registered byte address to the ROM.
REQ-014 SHALL have port rom_q_i, input, 8 bits: ROM data, valid one clock after the address is sampled.

Function
REQ-015 SHALL implement states IDLE, FETCH and RESP.
REQ-016 IDLE: when wb_cyc_i & wb_stb_i & !wb_we_i -> load rom_addr_o = {wb_adr_i[ROM_ADDR_WIDTH-1:2], 2'b00}, clear byte counter, go to FETCH.
REQ-017 FETCH: rom_addr_o increments by 1 per cycle for 3 cycles, presenting word-base+0..3 in consecutive cycles.
REQ-018 Byte k (base+k) SHALL be captured from rom_q_i two cycles after rom_addr_o was loaded with base+k, into wb_dat_o[8k+7:8k] (little-endian).
REQ-019 After byte 3 is captured -> RESP; wb_ack_o high for exactly one cycle with wb_dat_o stable; then IDLE.
REQ-020 Latency: strobe sampled in cycle 0 -> wb_ack_o high in cycle 6.
REQ-021 wb_dat_o SHALL hold its last value outside RESP.
REQ-022 Abort: wb_cyc_i or wb_stb_i low during FETCH -> IDLE on next edge, no ack, no err; wb_dat_o contents undefined-but-stable.
REQ-023 Back-to-back: a strobe still asserted in the cycle after RESP SHALL start a new fetch from IDLE (no ack recycling).
REQ-024 Word base never wraps; offsets 0..3 are added to an aligned base only.
REQ-025 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-026 rst high SHALL immediately force state IDLE, rom_addr_o = 0, wb_dat_o = 0, wb_ack_o = 0, wb_err_o = 0, byte counter = 0, including mid-FETCH.

Configuration
REQ-027 Macro WB_ROM_ERR_EN defined: a write strobe, or a read with any wb_adr_i bit at or above ROM_ADDR_WIDTH set, SHALL get wb_err_o high for one cycle, in the cycle after the strobe, with no ROM access.
REQ-028 WB_ROM_ERR_EN undefined: writes SHALL get wb_ack_o one cycle after the strobe with no effect, upper address bits SHALL be ignored, and wb_err_o SHALL be tied 0.

Structure
REQ-029 Package wb_rom_pkg SHALL hold the state enum, WB_DATA_WIDTH = 32 and BYTES_PER_WORD = 4.
REQ-030 SHALL contain no sub-module; the ROM is instantiated alongside by the parent and wired via rom_addr_o and rom_q_i.

Verification
REQ-031 The bench SHALL model the ROM as 1-cycle registered, loaded with byte[i] = i[7:0], and cover the directed scenarios below.
REQ-032 Read 0x0000_0004 -> ack in cycle 6, wb_dat_o = 0x07060504.
REQ-033 Read 0x0000_0007 (unaligned) -> wb_dat_o = 0x07060504, low address bits ignored.
REQ-034 Read 0x10, then drop wb_stb_i in cycle 3 -> no ack; a following read of 0x20 -> 0x23222120.
REQ-035 rst pulsed in cycle 4 of a fetch -> all outputs 0 asynchronously; the next read of 0x0 -> 0x03020100.
REQ-036 Write to 0x0 -> WB_ROM_ERR_EN defined: wb_err_o high in cycle 1; WB_ROM_ERR_EN undefined: wb_ack_o high in cycle 1; ROM address never advances in either case.
REQ-037 Two back-to-back reads of 0x8 and 0xC -> two single-cycle acks returning 0x0B0A0908 and 0x0F0E0D0C.

Source files
------------

// File: rtl/wb_rom_pkg.sv
// Shared types and constants for the Wishbone byte-ROM word reader.
package wb_rom_pkg;
  localparam int WB_DATA_WIDTH  = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;
endpackage

// File: rtl/wb_rom_reader.sv
// Wishbone slave that assembles a 32-bit little-endian word from four reads of an 8-bit registered ROM.
// Define WB_ROM_ERR_EN to error-acknowledge writes and out-of-range reads instead of silently acking.
module wb_rom_reader
  import wb_rom_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int WB_ADDR_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WB_ADDR_WIDTH-1:0]  wb_adr_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  output logic [WB_DATA_WIDTH-1:0]  wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [7:0]                rom_q_i
);

  state_e                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [WB_DATA_WIDTH-1:0]  dat_q, dat_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic                      req;
  logic                      addr_bad;
  logic [1:0]                byte_idx;
  logic                      unused_ok;

  assign req = wb_cyc_i & wb_stb_i;
  // Byte selects are meaningless for a read-only word fetch.
  assign unused_ok = ^{wb_sel_i, wb_adr_i};

`ifdef WB_ROM_ERR_EN
  assign addr_bad = (wb_adr_i >> ROM_ADDR_WIDTH) != '0;
`else
  assign addr_bad = 1'b0;
`endif

  // The ROM output trails the address by one clock, so capture k uses counter value k+1.
  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wb_we_i) begin
`ifdef WB_ROM_ERR_EN
            err_d = 1'b1;
`else
            ack_d = 1'b1;
`endif
            state_d = RESP;
          end else if (addr_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            rom_addr_d = {wb_adr_i[ROM_ADDR_WIDTH-1:2], 2'b00};
            cnt_d      = 3'd0;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        if (!req) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          if (cnt_q < 3'd3) rom_addr_d = rom_addr_q + 1'b1;
          if (cnt_q != 3'd0) dat_d[{byte_idx, 3'b000} +: 8] = rom_q_i;
          if (cnt_q == 3'd4) begin
            ack_d   = 1'b1;
            state_d = RESP;
          end
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign rom_addr_o = rom_addr_q;

endmodule
